// File: rtl/eq_pkg.sv
// Shared definitions for the equalizer menu: band count, gain limits, state codes
// and the 5-bit signed gain type used by the menu, display decoder and filter bank.
package eq_pkg;

  localparam int N_BANDS  = 8;
  localparam int GAIN_MIN = -12;
  localparam int GAIN_MAX = 12;

  typedef logic [2:0] state_t;

  // Codes are driven straight onto the seven-segment display, so they are fixed.
  localparam state_t StIdle   = 3'd0;
  localparam state_t StBand   = 3'd1;
  localparam state_t StGain   = 3'd2;
  localparam state_t StCommit = 3'd3;
  localparam state_t StBypass = 3'd4;

  typedef logic signed [4:0] gain_t;

  function automatic logic [15:0] gain_sext(input gain_t g);
    return {{11{g[4]}}, g};
  endfunction

endpackage

// File: rtl/eq_gain_table.sv
// Per-band stored gain registers: one synchronous write port, one combinational read port.
module eq_gain_table #(
  parameter int N_BANDS = eq_pkg::N_BANDS
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [2:0]    waddr_i,
  input  eq_pkg::gain_t wdata_i,
  input  logic [2:0]    raddr_i,
  output eq_pkg::gain_t rdata_o
);

  eq_pkg::gain_t mem_q [N_BANDS];

  for (genvar g = 0; g < N_BANDS; g++) begin : gen_entry
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        mem_q[g] <= '0;
      end else if (we_i && (waddr_i == 3'(g))) begin
        mem_q[g] <= wdata_i;
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < N_BANDS; i++) begin
      if (raddr_i == 3'(i)) begin
        rdata_o = mem_q[i];
      end
    end
  end

endmodule

// File: rtl/eq_menu_ctrl.sv
// Key-driven equalizer menu: pick a band, edit its gain, commit it to the filter bank
// through a req/ack handshake; bypass and an idle timeout abandon any uncommitted edit.
module eq_menu_ctrl #(
  parameter int          N_BANDS     = eq_pkg::N_BANDS,
  parameter int          GAIN_MIN    = eq_pkg::GAIN_MIN,
  parameter int          GAIN_MAX    = eq_pkg::GAIN_MAX,
  parameter int unsigned TIMEOUT_CYC = 1048576
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_select,
  input  logic        i_back,
  input  logic        i_up,
  input  logic        i_down,
  input  logic        i_bypass,
  input  logic        i_cfg_ack,
  output logic [2:0]  o_state,
  output logic [2:0]  o_band,
  output logic [15:0] o_gain,
  output logic        o_cfg_req,
  output logic [2:0]  o_cfg_band,
  output logic [15:0] o_cfg_gain
);

  localparam int unsigned     TmoW     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT_CYC - 1);
  localparam logic [2:0]      BandLast = 3'(N_BANDS - 1);
  localparam eq_pkg::gain_t   GainHi   = eq_pkg::gain_t'(GAIN_MAX);
  localparam eq_pkg::gain_t   GainLo   = eq_pkg::gain_t'(GAIN_MIN);

  eq_pkg::state_t  state_q, state_d;
  logic [2:0]      band_q, band_d;
  eq_pkg::gain_t   wgain_q, wgain_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            cfg_req_q, cfg_req_d;
  logic [2:0]      cfg_band_q, cfg_band_d;
  eq_pkg::gain_t   cfg_gain_q, cfg_gain_d;
  logic [15:0]     gain_q, gain_d;

  eq_pkg::gain_t   rd_gain, shown_gain;
  logic            k_back, k_sel, k_up, k_dn;
  logic            tmo_hit, acted, tbl_we;

  // One key per cycle: back > select > up > down.
  assign k_back  = i_back;
  assign k_sel   = i_select & ~i_back;
  assign k_up    = i_up & ~i_select & ~i_back;
  assign k_dn    = i_down & ~i_up & ~i_select & ~i_back;
  assign tmo_hit = (tmo_q == TmoLast);

  // Kept separate from the main decode so the table read address has no path from rd_gain.
  always_comb begin
    band_d = band_q;
    if ((state_q == eq_pkg::StBand) && !i_bypass && !tmo_hit) begin
      if (k_up) begin
        band_d = (band_q == BandLast) ? 3'd0 : band_q + 3'd1;
      end else if (k_dn) begin
        band_d = (band_q == 3'd0) ? BandLast : band_q - 3'd1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wgain_d    = wgain_q;
    cfg_req_d  = cfg_req_q;
    cfg_band_d = cfg_band_q;
    cfg_gain_d = cfg_gain_q;
    acted      = 1'b0;
    tbl_we     = 1'b0;
    case (state_q)
      eq_pkg::StIdle: begin
        if (i_bypass) begin
          state_d = eq_pkg::StBypass;
        end else if (k_sel) begin
          state_d = eq_pkg::StBand;
          acted   = 1'b1;
        end
      end
      eq_pkg::StBand: begin
        if (i_bypass) begin
          state_d = eq_pkg::StBypass;
        end else if (tmo_hit) begin
          state_d = eq_pkg::StIdle;
        end else if (k_back) begin
          state_d = eq_pkg::StIdle;
          acted   = 1'b1;
        end else if (k_sel) begin
          state_d = eq_pkg::StGain;
          wgain_d = rd_gain;
          acted   = 1'b1;
        end else if (k_up || k_dn) begin
          acted = 1'b1;
        end
      end
      eq_pkg::StGain: begin
        if (i_bypass) begin
          state_d = eq_pkg::StBypass;
        end else if (tmo_hit) begin
          state_d = eq_pkg::StIdle;
        end else if (k_back) begin
          state_d = eq_pkg::StBand;
          acted   = 1'b1;
        end else if (k_sel) begin
          state_d    = eq_pkg::StCommit;
          cfg_req_d  = 1'b1;
          cfg_band_d = band_q;
          cfg_gain_d = wgain_q;
          acted      = 1'b1;
        end else if (k_up) begin
          if (wgain_q < GainHi) wgain_d = wgain_q + 5'sd1;
          acted = 1'b1;
        end else if (k_dn) begin
          if (wgain_q > GainLo) wgain_d = wgain_q - 5'sd1;
          acted = 1'b1;
        end
      end
      eq_pkg::StCommit: begin
        if (cfg_req_q && i_cfg_ack) begin
          tbl_we    = 1'b1;
          cfg_req_d = 1'b0;
          state_d   = eq_pkg::StBand;
        end
      end
      eq_pkg::StBypass: begin
        if (!i_bypass) state_d = eq_pkg::StIdle;
      end
      default: state_d = eq_pkg::StIdle;
    endcase
  end

  always_comb begin
    tmo_d = tmo_q;
    if (acted || (state_d != state_q)) begin
      tmo_d = '0;
    end else if ((state_q == eq_pkg::StBand) || (state_q == eq_pkg::StGain)) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Forward a same-cycle commit so the display never shows the stale table entry.
  always_comb begin
    if ((state_d == eq_pkg::StGain) || (state_d == eq_pkg::StCommit)) begin
      shown_gain = wgain_d;
    end else if (tbl_we && (cfg_band_q == band_d)) begin
      shown_gain = cfg_gain_q;
    end else begin
      shown_gain = rd_gain;
    end
    gain_d = eq_pkg::gain_sext(shown_gain);
  end

  eq_gain_table #(
    .N_BANDS (N_BANDS)
  ) u_gain_table (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .we_i    (tbl_we),
    .waddr_i (cfg_band_q),
    .wdata_i (cfg_gain_q),
    .raddr_i (band_d),
    .rdata_o (rd_gain)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= eq_pkg::StIdle;
      band_q     <= '0;
      wgain_q    <= '0;
      tmo_q      <= '0;
      cfg_req_q  <= 1'b0;
      cfg_band_q <= '0;
      cfg_gain_q <= '0;
      gain_q     <= '0;
    end else begin
      state_q    <= state_d;
      band_q     <= band_d;
      wgain_q    <= wgain_d;
      tmo_q      <= tmo_d;
      cfg_req_q  <= cfg_req_d;
      cfg_band_q <= cfg_band_d;
      cfg_gain_q <= cfg_gain_d;
      gain_q     <= gain_d;
    end
  end

  assign o_state    = state_q;
  assign o_band     = band_q;
  assign o_gain     = gain_q;
  assign o_cfg_req  = cfg_req_q;
  assign o_cfg_band = cfg_band_q;
  assign o_cfg_gain = eq_pkg::gain_sext(cfg_gain_q);

endmodule

// File: tb/tb_eq_menu_ctrl.sv
// Scoreboard bench for eq_menu_ctrl: a behavioural menu model queues the expected outputs
// for every clock and a monitor compares them against the DUT on the falling edge.
module tb_eq_menu_ctrl;

  localparam int NB   = 8;
  localparam int TO   = 16;
  localparam int GMIN = -12;
  localparam int GMAX = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0, back = 1'b0, up = 1'b0, dn = 1'b0, byp = 1'b0, ack = 1'b0;
  logic [2:0]  o_state, o_band, o_cfg_band;
  logic [15:0] o_gain, o_cfg_gain;
  logic        o_cfg_req;

  eq_menu_ctrl #(
    .N_BANDS     (NB),
    .GAIN_MIN    (GMIN),
    .GAIN_MAX    (GMAX),
    .TIMEOUT_CYC (TO)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_select   (sel),
    .i_back     (back),
    .i_up       (up),
    .i_down     (dn),
    .i_bypass   (byp),
    .i_cfg_ack  (ack),
    .o_state    (o_state),
    .o_band     (o_band),
    .o_gain     (o_gain),
    .o_cfg_req  (o_cfg_req),
    .o_cfg_band (o_cfg_band),
    .o_cfg_gain (o_cfg_gain)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st; int band; int gain; int req; int cband; int cgain;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model: menu position, working gain, stored gains, idle count, pending write.
  int m_st, m_band, m_w, m_tmo, m_req, m_cband, m_cgain;
  int m_gains[NB];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_band = 0; m_w = 0; m_tmo = 0; m_req = 0; m_cband = 0; m_cgain = 0;
    for (int i = 0; i < NB; i++) m_gains[i] = 0;
  endtask

  task automatic model_push();
    exp_t e;
    e.st    = m_st;
    e.band  = m_band;
    e.gain  = (m_st == 2 || m_st == 3) ? m_w : m_gains[m_band];
    e.req   = m_req;
    e.cband = m_cband;
    e.cgain = m_cgain;
    exp_q.push_back(e);
  endtask

  task automatic model_step(input bit s, input bit b, input bit u, input bit d,
                            input bit p, input bit a);
    int  ns;
    int  key;  // 0 none, 1 back, 2 select, 3 up, 4 down
    bit  used;
    ns   = m_st;
    used = 0;
    key  = b ? 1 : s ? 2 : u ? 3 : d ? 4 : 0;
    if (m_st == 0) begin
      if (p) ns = 4;
      else if (key == 2) begin ns = 1; used = 1; end
    end else if (m_st == 1 || m_st == 2) begin
      if (p) ns = 4;
      else if (m_tmo == TO - 1) ns = 0;
      else if (key != 0) begin
        used = 1;
        if (m_st == 1) begin
          case (key)
            1: ns = 0;
            2: begin m_w = m_gains[m_band]; ns = 2; end
            3: m_band = (m_band + 1) % NB;
            default: m_band = (m_band + NB - 1) % NB;
          endcase
        end else begin
          case (key)
            1: ns = 1;
            2: begin ns = 3; m_req = 1; m_cband = m_band; m_cgain = m_w; end
            3: m_w = (m_w + 1 > GMAX) ? GMAX : m_w + 1;
            default: m_w = (m_w - 1 < GMIN) ? GMIN : m_w - 1;
          endcase
        end
      end
    end else if (m_st == 3) begin
      if (m_req == 1 && a) begin
        m_gains[m_cband] = m_cgain;
        m_req = 0;
        ns = 1;
      end
    end else begin
      if (!p) ns = 0;
    end
    if (used || ns != m_st) m_tmo = 0;
    else if (m_st == 1 || m_st == 2) m_tmo++;
    m_st = ns;
  endtask

  task automatic step(input bit s, input bit b, input bit u, input bit d,
                      input bit p, input bit a);
    @(negedge clk);
    sel = s; back = b; up = u; dn = d; byp = p; ack = a;
    @(posedge clk);
    model_step(s, b, u, d, p, a);
    model_push();
    #1;
  endtask

  task automatic press(input bit s, input bit b, input bit u, input bit d, input int n);
    for (int i = 0; i < n; i++) step(s, b, u, d, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sel = 0; back = 0; up = 0; dn = 0; byp = 0; ack = 0;
    model_reset();
    @(posedge clk);
    model_push();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("sb_state", int'(o_state), mon_e.st);
      chk("sb_band", int'(o_band), mon_e.band);
      chk("sb_gain", int'($signed(o_gain)), mon_e.gain);
      chk("sb_cfg_req", int'(o_cfg_req), mon_e.req);
      if (mon_e.req == 1) begin
        chk("sb_cfg_band", int'(o_cfg_band), mon_e.cband);
        chk("sb_cfg_gain", int'($signed(o_cfg_gain)), mon_e.cgain);
      end
    end
  end

  bit r_s, r_b, r_u, r_d, r_a, r_p;

  initial begin
    model_reset();
    @(posedge clk);
    model_push();
    #1;
    chk("reset_state", int'(o_state), 0);
    chk("reset_gain", int'(o_gain), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Band wrap in both directions.
    press(1, 0, 0, 0, 1);
    press(0, 0, 0, 1, 1);
    chk("wrap_down_band", int'(o_band), 7);
    press(0, 0, 1, 0, 1);
    chk("wrap_up_band", int'(o_band), 0);

    // Gain saturation on band 2.
    press(0, 0, 1, 0, 2);
    press(1, 0, 0, 0, 1);
    press(0, 0, 1, 0, 15);
    chk("sat_max_gain", int'($signed(o_gain)), 12);
    press(0, 0, 0, 1, 30);
    chk("sat_min_gain", int'($signed(o_gain)), -12);
    press(0, 1, 0, 0, 1);

    // Commit +5 to band 3 with a delayed acknowledge.
    press(0, 0, 1, 0, 1);
    press(1, 0, 0, 0, 1);
    press(0, 0, 1, 0, 5);
    press(1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
    chk("commit_req_held", int'(o_cfg_req), 1);
    chk("commit_band_held", int'(o_cfg_band), 3);
    chk("commit_gain_held", int'($signed(o_cfg_gain)), 5);
    step(0, 0, 0, 0, 0, 1);
    chk("commit_req_drop", int'(o_cfg_req), 0);
    chk("commit_state_band", int'(o_state), 1);
    chk("commit_stored", int'($signed(o_gain)), 5);

    // Discard by back, then by bypass, on band 1.
    press(0, 0, 0, 1, 2);
    press(1, 0, 0, 0, 1);
    press(0, 0, 1, 0, 4);
    press(0, 1, 0, 0, 1);
    chk("discard_back_state", int'(o_state), 1);
    chk("discard_back_gain", int'($signed(o_gain)), 0);
    press(1, 0, 0, 0, 1);
    press(0, 0, 1, 0, 4);
    step(1, 0, 1, 0, 1, 0);
    chk("bypass_state", int'(o_state), 4);
    step(0, 0, 0, 0, 0, 0);
    press(1, 0, 0, 0, 1);
    chk("bypass_band1_stored", int'($signed(o_gain)), 0);

    // Same-cycle key priority, then the idle timeout.
    press(1, 0, 0, 0, 1);
    press(0, 0, 1, 0, 1);
    press(1, 1, 1, 0, 1);
    chk("prio_state", int'(o_state), 1);
    chk("prio_band", int'(o_band), 1);
    press(0, 0, 0, 0, 15);
    chk("tmo_not_yet", int'(o_state), 1);
    press(0, 0, 0, 0, 1);
    chk("tmo_idle", int'(o_state), 0);

    // Reset while a commit is outstanding drops the request at once.
    press(1, 0, 0, 0, 2);
    press(0, 0, 1, 0, 1);
    press(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", int'(o_cfg_req), 0);
    chk("async_rst_state", int'(o_state), 0);
    model_reset();
    @(posedge clk);
    model_push();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic with bursts of silence long enough to trip the timeout.
    r_p = 0;
    for (int i = 0; i < 3000; i++) begin
      if (r_p) r_p = ($urandom_range(0, 99) >= 15);
      else     r_p = ($urandom_range(0, 99) < 2);
      if ((i % 300) >= 275) begin
        r_s = 0; r_b = 0; r_u = 0; r_d = 0;
      end else begin
        r_s = ($urandom_range(0, 99) < 15);
        r_b = ($urandom_range(0, 99) < 6);
        r_u = ($urandom_range(0, 99) < 25);
        r_d = ($urandom_range(0, 99) < 25);
      end
      r_a = ($urandom_range(0, 99) < 35);
      step(r_s, r_b, r_u, r_d, r_p, r_a);
      if (i == 1500) do_reset();
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
